gesture_power_ctrl: RTL and testbench
=====================================

// Module: gesture_power_ctrl
// PURPOSE
//  Gesture-based power switch for the hood. Consumes the gesture window length
//  (second_gesture, 0..59 s) produced by the duration-setting stage.
//  Power-on gesture: left key, then right key within the window.
//  Power-off gesture: right key, then left key within the window.
//  A dedicated power key toggles power directly and overrides any gesture in progress.
// PARAMETERS
//  TICKS_PER_SEC  100  clk_100Hz cycles per second of gesture window
// PORTS
//  clk_100Hz              in   1  system clock, 100 Hz
//  rst_n                  in   1  asynchronous, active-low reset
//  left_press_once        in   1  1-cycle pulse, left key (debounced)
//  right_press_once       in   1  1-cycle pulse, right key (debounced)
//  power_key_press_once   in   1  1-cycle pulse, power key (debounced)
//  second_gesture         in   6  gesture window in seconds (0..59)
//  power_on               out  1  registered; 1 = hood powered
//  gesture_armed          out  1  registered; 1 = first gesture key seen, window open
//  remaining_s            out  6  registered; seconds left in window, 0 when not armed
// BEHAVIOUR
//  - Clock and reset: one clock (clk_100Hz). rst_n is asynchronous, active-low.
//  - Reset values:
//    - state = OFF_IDLE; power_on = 0; gesture_armed = 0; remaining_s = 0.
//    - Internal tick counter = 0; seconds counter = 0.
//  - States, with power_on and gesture_armed in each:
//    - OFF_IDLE: power_on = 0, gesture_armed = 0.
//    - OFF_ARMED: power_on = 0, gesture_armed = 1.
//    - ON_IDLE: power_on = 1, gesture_armed = 0.
//    - ON_ARMED: power_on = 1, gesture_armed = 1.
//    - All outputs come from registers and change on the edge after the pulse that causes them (latency 1).
//  - Input priority, evaluated per cycle, highest first:
//    1. power_key_press_once: OFF_* -> ON_IDLE; ON_* -> OFF_IDLE.
//       Window cleared; left/right inputs ignored that cycle.
//    2. left_press_once and right_press_once both high in the same cycle: ignored, no state change.
//    3. Gesture keys:
//       - OFF_IDLE: left arms -> OFF_ARMED. Right ignored.
//       - ON_IDLE: right arms -> ON_ARMED. Left ignored.
//       - OFF_ARMED: right -> ON_IDLE. Left re-arms (window reloaded, still OFF_ARMED).
//       - ON_ARMED: left -> OFF_IDLE. Right re-arms (window reloaded, still ON_ARMED).
//    4. Expiry: OFF_ARMED -> OFF_IDLE; ON_ARMED -> ON_IDLE.
//  - Window timing, with N = second_gesture sampled at the arming cycle T:
//    - At arming: seconds counter <= N; tick <= TICKS_PER_SEC-1; remaining_s <= N.
//    - Each armed cycle with no higher-priority event:
//      - tick != 0: tick--.
//      - tick == 0 and seconds > 1: seconds--, tick reloads.
//      - tick == 0 and seconds == 1: expire.
//    - A completing key is accepted in cycles T+1 .. T+N*TICKS_PER_SEC inclusive.
//      The expiry cycle is included, because the completing key outranks expiry.
//    - remaining_s tracks the seconds counter (ceil of ticks left / TICKS_PER_SEC).
//  - N == 0: the arming key is ignored; the gesture is disabled.
//  - Changes to second_gesture while armed do not affect the current window.
//  - Counter widths: tick is 7 bits; seconds is 6 bits. No overflow is possible since N <= 59.
//  - Returning to any *_IDLE state forces remaining_s = 0 on the same edge.
//  - rst_n asserted mid-window: immediate OFF_IDLE, all outputs 0, window discarded.
// TESTING
//  1. Reset: hold rst_n=0, then release.
//     -> power_on=0, gesture_armed=0, remaining_s=0; pulses during reset have no effect.
//  2. N=5: left pulse at T, right pulse at T+300.
//     -> gesture_armed=1 and remaining_s=5 at T+1; power_on=1 and gesture_armed=0 at T+301.
//  3. N=1: left at T, right at T+100 -> power_on=1 at T+101 (last legal cycle).
//     Repeat with right at T+101 -> gesture_armed=0 at T+101 and power_on stays 0.
//  4. Power on, N=3: right at T, left at T+50 -> power_on=0 at T+51.
//     While off, right then left -> no change.
//  5. Left and right pulses in the same cycle -> ignored.
//     Power key while OFF_ARMED -> power_on=1, gesture_armed=0 next cycle.
//  6. Ignore and reset cases:
//     - N=0 with a left pulse -> gesture_armed stays 0.
//     - N=5, armed, change second_gesture to 2 -> expiry still occurs after 500 cycles.
//     - Assert rst_n mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/gesture_power_ctrl_if.sv
// gesture_power_ctrl_if
//   Bundles the key pulses, the gesture window length and the status outputs
//   of the gesture power switch.
//   master : drives the key pulses and second_gesture, observes the status
//   slave  : the power controller itself
//   left_press_once / right_press_once / power_key_press_once : 1-cycle pulses
//   second_gesture : gesture window in seconds (0..59)
//   power_on / gesture_armed / remaining_s : registered status
interface gesture_power_ctrl_if;
  logic       left_press_once;
  logic       right_press_once;
  logic       power_key_press_once;
  logic [5:0] second_gesture;
  logic       power_on;
  logic       gesture_armed;
  logic [5:0] remaining_s;

  modport master (
    output left_press_once, right_press_once, power_key_press_once, second_gesture,
    input  power_on, gesture_armed, remaining_s
  );

  modport slave (
    input  left_press_once, right_press_once, power_key_press_once, second_gesture,
    output power_on, gesture_armed, remaining_s
  );
endinterface

// File: rtl/gesture_power_ctrl.sv
// gesture_power_ctrl
//   Gesture-based power switch for the hood. Left-then-right within the
//   window powers on, right-then-left powers off; the power key toggles
//   power directly and cancels any gesture in progress.
//   clk_100Hz : system clock, 100 Hz
//   rst_n     : asynchronous, active-low reset
//   gp        : key pulses, window length in, power/armed/remaining_s out
module gesture_power_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input logic                 clk_100Hz,
  input logic                 rst_n,
  gesture_power_ctrl_if.slave gp
);

  // Encoding is {power_on, gesture_armed} so both outputs are flop bits.
  typedef enum logic [1:0] {
    OFF_IDLE  = 2'b00,
    OFF_ARMED = 2'b01,
    ON_IDLE   = 2'b10,
    ON_ARMED  = 2'b11
  } state_t;

  localparam logic [6:0] TICK_RELOAD = 7'(TICKS_PER_SEC - 1);

  state_t     state_q, state_d;
  logic [6:0] tick_q, tick_d;
  logic [5:0] sec_q, sec_d;
  logic       n_valid;
  logic       load;
  logic       count;

  assign n_valid = (gp.second_gesture != '0);

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF_IDLE;
      tick_q  <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    sec_d   = sec_q;
    load    = 1'b0;
    count   = 1'b0;

    if (gp.power_key_press_once) begin
      state_d = state_q[1] ? OFF_IDLE : ON_IDLE;
    end else if (gp.left_press_once && gp.right_press_once) begin
      // Simultaneous keys outrank expiry, so the window is held for this cycle.
      state_d = state_q;
    end else begin
      case (state_q)
        OFF_IDLE: if (gp.left_press_once && n_valid) begin
          state_d = OFF_ARMED;
          load    = 1'b1;
        end
        ON_IDLE: if (gp.right_press_once && n_valid) begin
          state_d = ON_ARMED;
          load    = 1'b1;
        end
        OFF_ARMED: begin
          if (gp.right_press_once)                   state_d = ON_IDLE;
          else if (gp.left_press_once && n_valid)    load    = 1'b1;
          else                                       count   = 1'b1;
        end
        ON_ARMED: begin
          if (gp.left_press_once)                    state_d = OFF_IDLE;
          else if (gp.right_press_once && n_valid)   load    = 1'b1;
          else                                       count   = 1'b1;
        end
      endcase
    end

    if (load) begin
      sec_d  = gp.second_gesture;
      tick_d = TICK_RELOAD;
    end else if (count) begin
      if (tick_q != '0) begin
        tick_d = tick_q - 7'd1;
      end else if (sec_q > 6'd1) begin
        sec_d  = sec_q - 6'd1;
        tick_d = TICK_RELOAD;
      end else begin
        state_d = (state_q == ON_ARMED) ? ON_IDLE : OFF_IDLE;
      end
    end

    if (state_d == OFF_IDLE || state_d == ON_IDLE) begin
      tick_d = '0;
      sec_d  = '0;
    end
  end

  assign gp.power_on      = state_q[1];
  assign gp.gesture_armed = state_q[0];
  assign gp.remaining_s   = sec_q;

endmodule

// File: tb/tb_gesture_power_ctrl.sv
module tb_gesture_power_ctrl;
  localparam int TPS = 100;

  logic clk_100Hz;
  logic rst_n;
  gesture_power_ctrl_if gp();

  gesture_power_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk_100Hz (clk_100Hz),
    .rst_n     (rst_n),
    .gp        (gp)
  );

  initial clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: power state, armed flag and the absolute cycle number
  // of the last cycle in which a completing key is still accepted.
  bit m_power;
  bit m_armed;
  int m_last;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_remaining();
    if (!m_armed) return 0;
    return (m_last - cyc + 1 + TPS - 1) / TPS;
  endfunction

  function automatic void model_reset();
    m_power = 1'b0;
    m_armed = 1'b0;
    m_last  = 0;
  endfunction

  // One clock cycle of the gesture rules, evaluated at cycle 'cyc'.
  function automatic void model_step(input bit l, input bit r, input bit pk, input int n);
    bit arm_key;
    bit done_key;
    arm_key  = m_power ? r : l;
    done_key = m_power ? l : r;
    if (pk) begin
      m_power = !m_power;
      m_armed = 1'b0;
    end else if (l && r) begin
      if (m_armed) m_last++;
    end else if (!m_armed) begin
      if (arm_key && n != 0) begin
        m_armed = 1'b1;
        m_last  = cyc + n * TPS;
      end
    end else if (done_key) begin
      m_power = !m_power;
      m_armed = 1'b0;
    end else if (arm_key && n != 0) begin
      m_last = cyc + n * TPS;
    end else if (cyc == m_last) begin
      m_armed = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    check("power_on",      32'(gp.power_on),      32'(m_power));
    check("gesture_armed", 32'(gp.gesture_armed), 32'(m_armed));
    check("remaining_s",   32'(gp.remaining_s),   32'(exp_remaining()));
  endtask

  task automatic drive_cycle(input bit l, input bit r, input bit pk, input logic [5:0] n);
    gp.left_press_once      = l;
    gp.right_press_once     = r;
    gp.power_key_press_once = pk;
    gp.second_gesture       = n;
    @(posedge clk_100Hz);
    model_step(l, r, pk, int'(n));
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int k, input logic [5:0] n);
    for (int i = 0; i < k; i++) drive_cycle(1'b0, 1'b0, 1'b0, n);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc   = 0;
    model_reset();
    gp.left_press_once      = 1'b0;
    gp.right_press_once     = 1'b0;
    gp.power_key_press_once = 1'b0;
    gp.second_gesture       = 6'd5;

    // Reset with pulses applied: nothing may change.
    #2;
    check("rst_power", 32'(gp.power_on), 32'd0);
    for (int i = 0; i < 4; i++) begin
      gp.left_press_once      = (i == 0);
      gp.right_press_once     = (i == 1);
      gp.power_key_press_once = (i == 2);
      @(posedge clk_100Hz);
      cyc++;
      #1;
      check_outputs();
    end
    gp.left_press_once      = 1'b0;
    gp.right_press_once     = 1'b0;
    gp.power_key_press_once = 1'b0;
    rst_n = 1'b1;
    idle(2, 6'd5);

    // N=5: left, right 300 cycles later -> on.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd5);
    check("t2_armed", 32'(gp.gesture_armed), 32'd1);
    check("t2_rem",   32'(gp.remaining_s),   32'd5);
    idle(299, 6'd5);
    drive_cycle(1'b0, 1'b1, 1'b0, 6'd5);
    check("t2_on", 32'(gp.power_on), 32'd1);
    drive_cycle(1'b0, 1'b0, 1'b1, 6'd5);  // power key -> off

    // N=1: right on the last legal cycle is accepted.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd1);
    idle(99, 6'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, 6'd1);
    check("t3_last_ok", 32'(gp.power_on), 32'd1);
    drive_cycle(1'b0, 1'b0, 1'b1, 6'd1);
    // One cycle late: window already closed.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd1);
    idle(100, 6'd1);
    check("t3_expired", 32'(gp.gesture_armed), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 6'd1);
    check("t3_late", 32'(gp.power_on), 32'd0);

    // Power on, N=3: right then left 50 cycles later -> off.
    drive_cycle(1'b0, 1'b0, 1'b1, 6'd3);
    drive_cycle(1'b0, 1'b1, 1'b0, 6'd3);
    idle(49, 6'd3);
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd3);
    check("t4_off", 32'(gp.power_on), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 6'd3);
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd3);  // arms only
    idle(400, 6'd3);

    // Simultaneous keys ignored; power key overrides an armed window.
    drive_cycle(1'b1, 1'b1, 1'b0, 6'd3);
    check("t5_both", 32'(gp.gesture_armed), 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd3);
    idle(10, 6'd3);
    drive_cycle(1'b1, 1'b1, 1'b0, 6'd3);
    drive_cycle(1'b0, 1'b0, 1'b1, 6'd3);
    check("t5_pk_on",    32'(gp.power_on),      32'd1);
    check("t5_pk_armed", 32'(gp.gesture_armed), 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 6'd3);

    // N=0 disables the gesture.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd0);
    check("t6_n0", 32'(gp.gesture_armed), 32'd0);

    // Window length is latched at arming.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd5);
    idle(499, 6'd2);
    check("t6_latched", 32'(gp.gesture_armed), 32'd1);
    idle(1, 6'd2);
    check("t6_expiry", 32'(gp.gesture_armed), 32'd0);

    // Asynchronous reset mid-window.
    drive_cycle(1'b1, 1'b0, 1'b0, 6'd4);
    idle(150, 6'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_armed", 32'(gp.gesture_armed), 32'd0);
    check("t6_rst_rem",   32'(gp.remaining_s),   32'd0);
    @(posedge clk_100Hz);
    cyc++;
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Randomised traffic with short windows so expiry is common.
    begin
      logic [5:0] n;
      n = 6'd2;
      for (int i = 0; i < 15000; i++) begin
        bit l, r, pk;
        if ($urandom_range(0, 199) == 0) n = 6'($urandom_range(0, 3));
        l  = ($urandom_range(0, 99) < 2);
        r  = ($urandom_range(0, 99) < 2);
        pk = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 499) == 0) begin
          l = 1'b1;
          r = 1'b1;
        end
        drive_cycle(l, r, pk, n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
